// File: rtl/multi_channel_averager.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_averager
// Purpose  : Per-channel sliding-window (boxcar) averager for ADC samples.
//            Each channel keeps a DEPTH-entry circular buffer and a running
//            sum; every accepted sample replaces the oldest entry and the
//            new window average is reported one cycle later.
// Ports    : clk          - rising-edge clock
//            reset_n      - asynchronous active-low reset
//            sample_valid - sample presented this cycle
//            sample_ch    - channel index of the sample (>= CHANNELS ignored)
//            sample_in    - unsigned sample value
//            hold         - freeze ave_out/ave_ch, accumulation continues
//            clear        - synchronous flush of all channel state
//            ave_out      - registered window average of last updated channel
//            ave_ch       - channel ave_out belongs to
//            ave_valid    - one-cycle pulse when ave_out/ave_ch update
//            primed       - bit c set once channel c has seen DEPTH samples
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_averager #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int LOG2_DEPTH   = 8,
  parameter int CHANNELS     = 2,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_valid,
  input  logic [CH_W-1:0]         sample_ch,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    hold,
  input  logic                    clear,
  output logic [SAMPLE_WIDTH-1:0] ave_out,
  output logic [CH_W-1:0]         ave_ch,
  output logic                    ave_valid,
  output logic [CHANNELS-1:0]     primed
);

  localparam int DEPTH  = 2 ** LOG2_DEPTH;
  // Exact width for DEPTH full-scale samples, so the sum can never overflow.
  localparam int SUM_W  = SAMPLE_WIDTH + LOG2_DEPTH;
  localparam int FILL_W = LOG2_DEPTH + 1;

  localparam logic [CH_W:0]     c_CHANNELS = (CH_W + 1)'(CHANNELS);
  localparam logic [FILL_W-1:0] c_DEPTH    = FILL_W'(DEPTH);

  logic                    w_accept;
  logic [SUM_W-1:0]        w_sum_next [CHANNELS];
  logic [SUM_W-1:0]        w_sel_sum;
  logic [SAMPLE_WIDTH-1:0] w_ave;

  // Extra leading zero lets a non-power-of-two channel count be compared.
  assign w_accept = sample_valid && ({1'b0, sample_ch} < c_CHANNELS) && !clear;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [SAMPLE_WIDTH-1:0] r_buf [DEPTH];
      logic [LOG2_DEPTH-1:0]   r_ptr;
      logic [SUM_W-1:0]        r_sum;
      logic [FILL_W-1:0]       r_fill;
      logic                    r_primed;
      logic                    w_hit;
      logic [SAMPLE_WIDTH-1:0] w_old;

      assign w_hit = w_accept && (sample_ch == CH_W'(c));
      assign w_old = r_buf[r_ptr];
      // Modular arithmetic: the intermediate sum+sample may wrap, but the
      // final result always fits SUM_W, so the truncated result is exact.
      assign w_sum_next[c] = r_sum + SUM_W'(sample_in) - SUM_W'(w_old);
      assign primed[c]     = r_primed;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
          r_ptr    <= '0;
          r_sum    <= '0;
          r_fill   <= '0;
          r_primed <= 1'b0;
        end else if (clear) begin
          for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
          r_ptr    <= '0;
          r_sum    <= '0;
          r_fill   <= '0;
          r_primed <= 1'b0;
        end else if (w_hit) begin
          r_buf[r_ptr] <= sample_in;
          r_ptr        <= r_ptr + 1'b1;   // natural wrap DEPTH-1 -> 0
          r_sum        <= w_sum_next[c];
          if (r_fill != c_DEPTH) begin
            r_fill <= r_fill + 1'b1;
          end
          if (r_fill == c_DEPTH - 1'b1) begin
            r_primed <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // Select the updated channel's new sum for the output average.
  always_comb begin
    w_sel_sum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sample_ch == CH_W'(c)) w_sel_sum = w_sum_next[c];
    end
  end

  assign w_ave = SAMPLE_WIDTH'(w_sel_sum >> LOG2_DEPTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ave_out   <= '0;
      ave_ch    <= '0;
      ave_valid <= 1'b0;
    end else if (clear) begin
      ave_out   <= '0;
      ave_ch    <= '0;
      ave_valid <= 1'b0;
    end else begin
      ave_valid <= w_accept && !hold;
      if (w_accept && !hold) begin
        ave_out <= w_ave;
        ave_ch  <= sample_ch;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_averager.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_averager
// Purpose  : Directed self-checking bench for multi_channel_averager with
//            CHANNELS=2, LOG2_DEPTH=2, SAMPLE_WIDTH=12. A second instance with
//            CHANNELS=3 exercises rejection of an out-of-range channel index.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_averager;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [0:0]  sample_ch;
  logic [11:0] sample_in;
  logic        hold;
  logic        clear;
  logic [11:0] ave_out;
  logic [0:0]  ave_ch;
  logic        ave_valid;
  logic [1:0]  primed;

  logic        valid3;
  logic [1:0]  ch3;
  logic [11:0] ave_out3;
  logic [1:0]  ave_ch3;
  logic        ave_valid3;
  logic [2:0]  primed3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_channel_averager #(
    .SAMPLE_WIDTH(12), .LOG2_DEPTH(2), .CHANNELS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_in(sample_in), .hold(hold), .clear(clear),
    .ave_out(ave_out), .ave_ch(ave_ch), .ave_valid(ave_valid), .primed(primed)
  );

  multi_channel_averager #(
    .SAMPLE_WIDTH(12), .LOG2_DEPTH(2), .CHANNELS(3)
  ) dut3 (
    .clk(clk), .reset_n(reset_n), .sample_valid(valid3),
    .sample_ch(ch3), .sample_in(sample_in), .hold(hold), .clear(clear),
    .ave_out(ave_out3), .ave_ch(ave_ch3), .ave_valid(ave_valid3),
    .primed(primed3)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one sample to both instances; returns #1 after the accepting edge.
  task automatic send(input logic [0:0] ch, input logic [11:0] val);
    sample_valid = 1'b1;
    sample_ch    = ch;
    sample_in    = val;
    valid3       = 1'b1;
    ch3          = {1'b0, ch};
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    valid3       = 1'b0;
  endtask

  task automatic expect_avg(input string tag, input logic [11:0] val,
                            input logic [0:0] ch);
    check({tag, "_valid"}, 32'(ave_valid), 32'd1);
    check({tag, "_out"},   32'(ave_out),   32'(val));
    check({tag, "_ch"},    32'(ave_ch),    32'(ch));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample_ch    = '0;
    sample_in    = '0;
    hold         = 1'b0;
    clear        = 1'b0;
    valid3       = 1'b0;
    ch3          = '0;

    // Reset state
    #3;
    check("rst_out",    32'(ave_out),   32'd0);
    check("rst_valid",  32'(ave_valid), 32'd0);
    check("rst_primed", 32'(primed),    32'd0);
    #9;
    reset_n = 1'b1;   // t=12: next edge at t=15 accepts a sample

    // Fill / prime ch0
    send(1'b0, 12'd100); expect_avg("fill1", 12'd25, 1'b0);
    send(1'b0, 12'd100); expect_avg("fill2", 12'd50, 1'b0);
    send(1'b0, 12'd100); expect_avg("fill3", 12'd75, 1'b0);
    check("primed_before", 32'(primed), 32'd0);
    send(1'b0, 12'd100); expect_avg("fill4", 12'd100, 1'b0);
    check("primed_ch0", 32'(primed), 32'd1);

    // Wrap: window 200,100,100,100 -> 500/4
    send(1'b0, 12'd200); expect_avg("wrap1", 12'd125, 1'b0);
    send(1'b0, 12'd200); check("wrap2", 32'(ave_out), 32'd150);
    send(1'b0, 12'd200); check("wrap3", 32'(ave_out), 32'd175);
    send(1'b0, 12'd200); check("wrap4", 32'(ave_out), 32'd200);
    send(1'b0, 12'd200); expect_avg("wrap5", 12'd200, 1'b0);
    idle();
    check("idle_valid", 32'(ave_valid), 32'd0);

    // Interleaved channels, full scale on ch1
    send(1'b1, 12'd4095); expect_avg("ch1_a", 12'd1023, 1'b1);
    send(1'b0, 12'd0);    expect_avg("ch0_a", 12'd150,  1'b0);
    send(1'b1, 12'd4095); check("ch1_b", 32'(ave_out), 32'd2047);
    send(1'b0, 12'd0);    check("ch0_b", 32'(ave_out), 32'd100);
    send(1'b1, 12'd4095); check("ch1_c", 32'(ave_out), 32'd3071);
    send(1'b0, 12'd0);    check("ch0_c", 32'(ave_out), 32'd50);
    send(1'b1, 12'd4095); expect_avg("ch1_full", 12'd4095, 1'b1);
    send(1'b0, 12'd0);    expect_avg("ch0_zero", 12'd0,    1'b0);
    check("primed_both", 32'(primed), 32'd3);

    // Out-of-range channel on the 3-channel instance is ignored
    sample_in = 12'd777;
    valid3    = 1'b1;
    ch3       = 2'd3;
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    check("bad_ch_valid",  32'(ave_valid3), 32'd0);
    check("bad_ch_out",    32'(ave_out3),   32'd0);
    check("bad_ch_primed", 32'(primed3),    32'd3);
    check("main_idle",     32'(ave_valid),  32'd0);

    // Hold
    send(1'b0, 12'd100); send(1'b0, 12'd100);
    send(1'b0, 12'd100); send(1'b0, 12'd100);
    expect_avg("pre_hold", 12'd100, 1'b0);
    hold = 1'b1;
    send(1'b0, 12'd0);
    check("hold1_valid", 32'(ave_valid), 32'd0);
    check("hold1_out",   32'(ave_out),   32'd100);
    send(1'b0, 12'd0);
    check("hold2_valid", 32'(ave_valid), 32'd0);
    check("hold2_out",   32'(ave_out),   32'd100);
    hold = 1'b0;
    send(1'b0, 12'd0);
    expect_avg("post_hold", 12'd25, 1'b0);

    // Asynchronous reset mid-stream
    sample_valid = 1'b1;
    sample_ch    = 1'b1;
    sample_in    = 12'd500;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out",    32'(ave_out),   32'd0);
    check("arst_valid",  32'(ave_valid), 32'd0);
    check("arst_primed", 32'(primed),    32'd0);
    sample_valid = 1'b0;
    idle();
    reset_n = 1'b1;
    send(1'b0, 12'd8);
    expect_avg("post_rst", 12'd2, 1'b0);
    check("post_rst_primed", 32'(primed), 32'd0);

    // Clear with a concurrent sample
    send(1'b1, 12'd4095); send(1'b1, 12'd4095);
    send(1'b1, 12'd4095); send(1'b1, 12'd4095);
    expect_avg("pre_clr", 12'd4095, 1'b1);
    check("pre_clr_primed", 32'(primed), 32'd2);
    clear = 1'b1;
    send(1'b0, 12'd4000);
    clear = 1'b0;
    check("clr_out",    32'(ave_out),   32'd0);
    check("clr_ch",     32'(ave_ch),    32'd0);
    check("clr_valid",  32'(ave_valid), 32'd0);
    check("clr_primed", 32'(primed),    32'd0);
    send(1'b0, 12'd40);
    expect_avg("post_clr", 12'd10, 1'b0);
    send(1'b1, 12'd4);
    expect_avg("post_clr_ch1", 12'd1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
